// File: rtl/uart_tx_engine_if.sv
// Handshake bundle between the TX FIFO/control side and the UART transmit engine.
// master drives enable and the FIFO head; slave (the engine) returns strobe and line status.
interface uart_tx_engine_if;
    logic       en;
    logic [7:0] fifo_data;
    logic       fifo_empty;
    logic       fifo_rd;
    logic       tx;
    logic       busy;
    logic       tx_done;

    modport master (
        output en, fifo_data, fifo_empty,
        input  fifo_rd, tx, busy, tx_done
    );

    modport slave (
        input  en, fifo_data, fifo_empty,
        output fifo_rd, tx, busy, tx_done
    );
endinterface

// File: rtl/uart_tx_engine.sv
// UART transmit serializer: pops bytes from the TX FIFO and shifts them out LSB-first as 8N1.
// Define UART_TX_PARITY_EN to insert an even-parity bit before stop (8E1).
module uart_tx_engine #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic            clk,
    input  logic            nrst,
    uart_tx_engine_if.slave bus
);
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             tx_done_q, tx_done_d;
    logic             bit_end;
    logic             fetch;

    // tx_d is the line level of the state being entered, so tx_q lines up with state_q.
    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        tx_d      = tx_q;
        tx_done_d = 1'b0;
        bit_end   = (clk_cnt_q == CNT_MAX);
        fetch     = nrst && (state_q == IDLE) && bus.en && !bus.fifo_empty;

        if (state_q != IDLE)
            clk_cnt_d = bit_end ? '0 : clk_cnt_q + 1'b1;

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (fetch) begin
                    shreg_d   = bus.fifo_data;
                    clk_cnt_d = '0;
                    bit_idx_d = '0;
                    state_d   = START;
                    tx_d      = 1'b0;
                end
            end
            START: if (bit_end) begin
                state_d   = DATA;
                bit_idx_d = '0;
                tx_d      = shreg_q[0];
            end
            DATA: if (bit_end) begin
                if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                    state_d = PARITY;
                    tx_d    = ^shreg_q;
`else
                    state_d = STOP;
                    tx_d    = 1'b1;
`endif
                end else begin
                    bit_idx_d = bit_idx_q + 3'd1;
                    tx_d      = shreg_q[bit_idx_q + 3'd1];
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (bit_end) begin
                state_d = STOP;
                tx_d    = 1'b1;
            end
`endif
            STOP: if (bit_end) begin
                state_d   = IDLE;
                tx_d      = 1'b1;
                tx_done_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q   <= IDLE;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            tx_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            tx_done_q <= tx_done_d;
        end
    end

    assign bus.fifo_rd = fetch;
    assign bus.tx      = tx_q;
    assign bus.busy    = busy_q;
    assign bus.tx_done = tx_done_q;
endmodule

// File: doc/uart_tx_engine.md
# uart_tx_engine

UART transmit serializer that drains the 32-entry TX byte FIFO and drives the serial line in 8N1 format (optionally 8E1). It sits directly downstream of the TX FIFO: it watches `fifo_empty`, samples the FIFO head byte, pulses the FIFO read strobe, and shifts the byte out LSB-first at a fixed baud rate derived from `clk`.

## Interface
- `CLKS_PER_BIT`, default 434: clk cycles per serial bit (50 MHz / 115200). Legal minimum is 2.
- `clk`  in  1  system clock; all logic on the rising edge.
- `nrst`  in  1  reset, synchronous, active-low.
- `en`  in  1  transmit enable; gates the start of new frames only.
- `fifo_data`  in  8  FIFO head byte at the current read pointer (combinational from the FIFO).
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_rd`  out  1  one-cycle read strobe; advances the FIFO read pointer.
- `tx`  out  1  serial output, registered, idle high.
- `busy`  out  1  high while a frame is in progress (state != IDLE).
- `tx_done`  out  1  one-cycle pulse on frame completion.

## Operation
- FSM states: IDLE, START, DATA, PARITY (only with the macro), STOP.
- Registers:
  - `clk_cnt`: $clog2(CLKS_PER_BIT) bits, counts 0..CLKS_PER_BIT-1, then wraps to 0 and ends the bit period.
  - `bit_idx`: 3 bits.
  - `shreg`: 8 bits.
- IDLE:
  - `tx`=1.
  - If `en` && !`fifo_empty`: assert `fifo_rd` combinationally for that cycle, latch `fifo_data` into `shreg`, clear the counters, go to START.
  - Otherwise stay in IDLE with `fifo_rd`=0.
- START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA with `bit_idx`=0.
- DATA:
  - `tx`=`shreg[bit_idx]`, LSB first, each bit held CLKS_PER_BIT cycles.
  - After bit 7, go to PARITY (macro defined) or STOP.
- PARITY: `tx`=even parity (XOR of the 8 latched bits) for CLKS_PER_BIT cycles, then go to STOP.
- STOP: `tx`=1 for CLKS_PER_BIT cycles, then go to IDLE and pulse `tx_done` for exactly one cycle (the first IDLE cycle).
- `fifo_rd` is never asserted outside IDLE. At most one strobe per frame.
- `en` deasserted mid-frame: the current frame completes normally. No new fetch occurs.
- `fifo_empty`=1 with `en`=1: remain in IDLE, `tx`=1, no strobe.
- `fifo_data` is sampled only at the strobe cycle. Later changes do not affect the frame.

## Timing
- Reset values (nrst=0 at a rising edge): state=IDLE, `tx`=1, `busy`=0, `tx_done`=0, `fifo_rd`=0, `clk_cnt`=0, `bit_idx`=0, `shreg`=0.
- Reset mid-frame: the line returns high at the next edge and the byte is discarded. `fifo_rd` stays 0 during reset.
- `tx` and `busy` are registered. The start bit appears on the edge after the `fifo_rd` cycle, which is also when `busy` rises.
- Frame length:
  - 10×CLKS_PER_BIT cycles without the macro.
  - 11×CLKS_PER_BIT cycles with the macro.
- Back-to-back frames:
  - Exactly one idle-high cycle between frames (the IDLE cycle carrying `tx_done` and the next `fifo_rd`).
  - `fifo_rd` period is 10×CLKS_PER_BIT+1 cycles (11×CLKS_PER_BIT+1 with the macro).
- `fifo_rd` and `tx_done` may be high in the same cycle.

## Configuration
- Macro: `UART_TX_PARITY_EN`.
- Defined: the PARITY state is compiled in and frames are 8E1, carrying one even-parity bit between bit 7 and stop.
- Undefined: the PARITY state and parity logic are absent, and frames are 8N1.

## Test plan
All scenarios use CLKS_PER_BIT=4.

- Reset: hold nrst=0 for 3 cycles with `en`=1 and `fifo_empty`=0 → `tx`=1, `busy`=0, `fifo_rd`=0, `tx_done`=0 throughout.
- Single byte: `fifo_data`=0xA5, `fifo_empty` falls, `en`=1 → one `fifo_rd` pulse. `tx` bit sequence is 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles. `tx_done` pulses 41 cycles after `fifo_rd`.
- Back-to-back: bytes 0x00 then 0xFF, FIFO non-empty for both → `fifo_rd` pulses 41 cycles apart, a single 1-cycle high gap between frames, then IDLE with `tx`=1 once `fifo_empty`=1.
- Enable drop: deassert `en` at cycle 10 of the 0x3C frame → the frame completes unchanged, `tx_done` pulses, no further `fifo_rd` although the FIFO is non-empty.
- Reset mid-frame: nrst=0 during bit 3 of 0x55 → `tx`=1 and `busy`=0 on the next edge. After release, a new frame starts with a fresh `fifo_rd`.
- Parity (macro defined): byte 0x07 → parity bit 1 and `fifo_rd` period 45. Byte 0x03 → parity bit 0.
